// File: rtl/icache_line_filler.sv
// icache_line_filler
//
// Purpose:
//   Fills one instruction-cache line on a miss. It latches the 32-byte-aligned
//   line base from the miss address and issues 8 sequential word reads on the
//   32-bit main-memory bus. It then assembles the returned words into the 256-bit
//   line format and pulses o_mem_ready for one cycle.
//   Only one line is in flight at a time.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   srst           synchronous active-high reset, overrides everything
//   i_mem_address  miss address from the cache; low 5 bits are ignored
//   i_mem_read     line-fill request (level), sampled only while idle
//   o_mem_data     last completed line, word k at [255-32k -: 32]
//   o_mem_ready    one-cycle pulse when o_mem_data holds the requested line
//   o_bus_address  word address on the memory bus (always 4-byte aligned)
//   o_bus_read     bus read request, held until i_bus_ack
//   i_bus_data     read data, valid with i_bus_ack
//   i_bus_ack      bus accepts the request and returns data in the same cycle
module icache_line_filler #(
    parameter int WORDS_PER_LINE = 8,
    parameter int WORD_WIDTH     = 32
) (
    input  logic                                 clk,
    input  logic                                 srst,
    input  logic [31:0]                          i_mem_address,
    input  logic                                 i_mem_read,
    output logic [WORDS_PER_LINE*WORD_WIDTH-1:0] o_mem_data,
    output logic                                 o_mem_ready,
    output logic [31:0]                          o_bus_address,
    output logic                                 o_bus_read,
    input  logic [WORD_WIDTH-1:0]                i_bus_data,
    input  logic                                 i_bus_ack
);

    localparam int LINE_WIDTH = WORDS_PER_LINE * WORD_WIDTH;
    localparam int CNT_W      = $clog2(WORDS_PER_LINE);
    // Byte offset of a word inside the line: word index followed by 2 zero bits.
    localparam int OFF_W      = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_DONE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [CNT_W-1:0]        count_next;
    logic [WORD_WIDTH-1:0]   line_reg [WORDS_PER_LINE];
    logic [LINE_WIDTH-1:0]   line_next;

    // The byte offset within the line never reaches the line base bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_mem_address[OFF_W-1:0];

    assign count_next = count_reg + CNT_W'(1);

    // Completed line image: the slot being acked right now takes the bus data
    // directly, so the final word does not need an extra cycle through line_reg.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            assign line_next[LINE_WIDTH-1-WORD_WIDTH*gi -: WORD_WIDTH] =
                (count_reg == CNT_W'(gi)) ? i_bus_data : line_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                line_reg[i] <= '0;
            end
            o_mem_data    <= '0;
            o_mem_ready   <= 1'b0;
            o_bus_address <= '0;
            o_bus_read    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_mem_read) begin
                        o_bus_address <= {i_mem_address[31:OFF_W], {OFF_W{1'b0}}};
                        o_bus_read    <= 1'b1;
                        count_reg     <= '0;
                        state_reg     <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    // The request inputs are deliberately not looked at here:
                    // once started, a fill always completes for the latched base.
                    if (i_bus_ack) begin
                        line_reg[count_reg] <= i_bus_data;
                        if (count_reg != LAST_WORD) begin
                            count_reg                <= count_next;
                            // Only the in-line offset advances; the base bits
                            // are never carried into, so the top line cannot wrap.
                            o_bus_address[OFF_W-1:0] <= {count_next, 2'b00};
                        end else begin
                            count_reg   <= '0;
                            o_bus_read  <= 1'b0;
                            o_mem_data  <= line_next;
                            o_mem_ready <= 1'b1;
                            state_reg   <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    o_mem_ready <= 1'b0;
                    state_reg   <= ST_HOLDOFF;
                end

                // The cache's registered request still shows the just-served
                // miss for one cycle after ready, so this cycle must not sample it.
                ST_HOLDOFF: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
